// File: rtl/mem_ctrl_pkg.sv
// Shared CPU definitions: load/store length encodings, RAM arbiter FSM states
// and the owner tag used by the byte-wide memory controller.
package cpu_defs;

  typedef enum logic [1:0] {
    LEN_1  = 2'b00,
    LEN_2  = 2'b01,
    LEN_4  = 2'b10,
    LEN_4X = 2'b11
  } mem_len_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10
  } mem_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } mem_owner_e;

  localparam logic [2:0] IF_LEN = 3'd4;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (mem_len_e'(len))
      LEN_1:   return 3'd1;
      LEN_2:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of the fetch, load/store and byte-RAM signals around mem_ctrl.
// slave = controller view, master = CPU + RAM view.
interface mem_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        flush;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata,
           flush, ram_din,
    output if_ack, if_data, mem_ack, mem_rdata, ram_a, ram_dout, ram_wr
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata,
           flush, ram_din,
    input  if_ack, if_data, mem_ack, mem_rdata, ram_a, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates one byte-wide synchronous RAM between instruction fetch and
// load/store, serialising 1/2/4-byte accesses one byte per cycle.
module mem_ctrl
  import cpu_defs::*;
(
  input  logic       clk,
  input  logic       rst_n,
  mem_ctrl_if.slave  bus
);

  mem_state_e  state_q, state_d;
  mem_owner_e  owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        if_ack_q, if_ack_d;
  logic        mem_ack_q, mem_ack_d;
  logic [31:0] rd_word;
  logic [31:0] wr_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      addr_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
    end
  end

  // ram_din holds the byte addressed in the previous cycle, i.e. index cnt_q-1.
  always_comb begin
    rd_word = buf_q;
    case (cnt_q)
      3'd1:    rd_word[7:0]   = bus.ram_din;
      3'd2:    rd_word[15:8]  = bus.ram_din;
      3'd3:    rd_word[23:16] = bus.ram_din;
      3'd4:    rd_word[31:24] = bus.ram_din;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        buf_d = '0;
        // A requester still seeing its own ack is not re-granted this cycle.
        if (bus.mem_req && !mem_ack_q) begin
          owner_d = OWN_MEM;
          addr_d  = bus.mem_addr;
          wdata_d = bus.mem_wdata;
          len_d   = len_bytes(bus.mem_len);
          state_d = bus.mem_we ? ST_WR : ST_RD;
        end else if (bus.if_req && !if_ack_q && !bus.flush) begin
          owner_d = OWN_IF;
          addr_d  = bus.if_addr;
          wdata_d = '0;
          len_d   = IF_LEN;
          state_d = ST_RD;
        end
      end

      ST_RD: begin
        if (owner_q == OWN_IF && bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          buf_d = rd_word;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == len_q) begin
            state_d = ST_IDLE;
            if (owner_q == OWN_IF) begin
              if_data_d = rd_word;
              if_ack_d  = 1'b1;
            end else begin
              mem_rdata_d = rd_word;
              mem_ack_d   = 1'b1;
            end
          end
        end
      end

      ST_WR: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == len_q - 3'd1) begin
          state_d   = ST_IDLE;
          mem_ack_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_shift = wdata_q >> {cnt_q[1:0], 3'b000};

  always_comb begin
    bus.ram_a    = '0;
    bus.ram_dout = '0;
    bus.ram_wr   = 1'b0;
    if (state_q != ST_IDLE) begin
      bus.ram_a = addr_q + {29'b0, cnt_q};
    end
    if (state_q == ST_WR && owner_q == OWN_MEM) begin
      bus.ram_dout = wr_shift[7:0];
      bus.ram_wr   = 1'b1;
    end
  end

  assign bus.if_ack    = if_ack_q;
  assign bus.if_data   = if_data_q;
  assign bus.mem_ack   = mem_ack_q;
  assign bus.mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, golden byte memory and
// directed plus randomized fetch/load/store scenarios.
module tb_mem_ctrl;
  import cpu_defs::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl_if bus();

  mem_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM contents as seen by the DUT, and the contents the spec says it should hold.
  logic [7:0] ram  [logic [31:0]];
  logic [7:0] gold [logic [31:0]];
  logic [7:0] din_q = 8'h00;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    din_q <= ram.exists(bus.ram_a) ? ram[bus.ram_a] : init_byte(bus.ram_a);
    if (bus.ram_wr) ram[bus.ram_a] = bus.ram_dout;
  end
  assign bus.ram_din = din_q;

  typedef struct {
    int          c;
    logic [31:0] a;
    logic [7:0]  d;
    logic        wr;
  } ev_t;
  ev_t tq[$];

  always @(negedge clk) tq.push_back('{cyc, bus.ram_a, bus.ram_dout, bus.ram_wr});

  function automatic logic [7:0] gold_rd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_byte(a);
  endfunction

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] gold_word(input logic [31:0] a, input int n);
    logic [31:0] w = '0;
    for (int i = 0; i < n; i++) w = w | ({24'h0, gold_rd(a + 32'(i))} << (8 * i));
    return w;
  endfunction

  function automatic logic [32:0] trace_at(input int c);
    foreach (tq[j]) if (tq[j].c == c) return {1'b1, tq[j].a};
    return '0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] v);
    ram[a]  = v;
    gold[a] = v;
  endtask

  task automatic run_xfer(input bit is_if, input bit we, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int ack_rel, output logic [31:0] data, output int t0);
    @(negedge clk);
    t0 = cyc;
    if (is_if) begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end else begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = we;
      bus.mem_len   = len;
      bus.mem_addr  = addr;
      bus.mem_wdata = wdata;
    end
    ack_rel = -1;
    data    = 'x;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (is_if ? bus.if_ack : bus.mem_ack) begin
        ack_rel = cyc - t0;
        data    = is_if ? bus.if_data : bus.mem_rdata;
        break;
      end
    end
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
  endtask

  task automatic test_reset();
    int rel;
    int t0;
    rst_n = 1'b0;
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'b10;
    bus.mem_addr = 32'h55; bus.mem_wdata = 32'hC0FFEE11;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.if_ack, bus.mem_ack, bus.ram_wr} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes got=%b want=000", {bus.if_ack, bus.mem_ack, bus.ram_wr});
    end
    n_tests++;
    if (bus.if_data !== 32'h0 || bus.mem_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_data got if=%h mem=%h want=0", bus.if_data, bus.mem_rdata);
    end
    n_tests++;
    if (bus.ram_a !== 32'h0 || bus.ram_dout !== 8'h0) begin
      n_fail++; $display("FAIL reset_ram got a=%h d=%h want=0", bus.ram_a, bus.ram_dout);
    end
    rst_n = 1'b1;
    t0 = cyc;
    #1;
    n_tests++;
    if (bus.ram_wr !== 1'b0 || bus.ram_a !== 32'h0) begin
      n_fail++; $display("FAIL reset_early_grant got wr=%b a=%h want 0", bus.ram_wr, bus.ram_a);
    end
    rel = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.mem_ack) begin rel = cyc - t0; break; end
    end
    bus.mem_req = 1'b0;
    n_tests++;
    if (rel !== 5) begin n_fail++; $display("FAIL reset_first_store ack_cycle got=%0d want=5", rel); end
    for (int i = 0; i < 4; i++) gold[32'h55 + 32'(i)] = 8'(32'hC0FFEE11 >> (8 * i));
  endtask

  task automatic test_if_fetch();
    int rel, t0; logic [31:0] d; logic [32:0] ta; int nwr;
    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h10); preload(32'h103, 8'h00);
    tq.delete();
    run_xfer(1'b1, 1'b0, 2'b10, 32'h100, '0, rel, d, t0);
    n_tests++;
    if (rel !== 6) begin n_fail++; $display("FAIL if_ack_cycle got=%0d want=6", rel); end
    n_tests++;
    if (d !== 32'h00100513) begin n_fail++; $display("FAIL if_data got=%h want=00100513", d); end
    for (int i = 0; i < 4; i++) begin
      ta = trace_at(t0 + 1 + i);
      n_tests++;
      if (ta !== {1'b1, 32'h100 + 32'(i)}) begin
        n_fail++; $display("FAIL if_addr_%0d got=%h want=%h", i, ta[31:0], 32'h100 + 32'(i));
      end
    end
    nwr = 0;
    foreach (tq[j]) if (tq[j].wr) nwr++;
    n_tests++;
    if (nwr !== 0) begin n_fail++; $display("FAIL if_no_write got=%0d writes want=0", nwr); end
    @(negedge clk);
    n_tests++;
    if (bus.if_ack !== 1'b0) begin n_fail++; $display("FAIL if_ack_one_cycle got=%b want=0", bus.if_ack); end
  endtask

  task automatic test_store_half();
    int rel, t0, nw; logic [31:0] d;
    tq.delete();
    run_xfer(1'b0, 1'b1, 2'b01, 32'h200, 32'hAABBCCDD, rel, d, t0);
    n_tests++;
    if (rel !== 3) begin n_fail++; $display("FAIL store_ack_cycle got=%0d want=3", rel); end
    nw = 0;
    foreach (tq[j]) begin
      if (tq[j].wr) begin
        n_tests++;
        if (tq[j].c - t0 !== nw + 1 || tq[j].a !== 32'h200 + 32'(nw)
            || tq[j].d !== 8'(32'hAABBCCDD >> (8 * nw))) begin
          n_fail++;
          $display("FAIL store_write_%0d got cyc=%0d a=%h d=%h want cyc=%0d a=%h d=%h", nw,
                   tq[j].c - t0, tq[j].a, tq[j].d, nw + 1, 32'h200 + 32'(nw), 8'(32'hAABBCCDD >> (8 * nw)));
        end
        nw++;
      end
    end
    n_tests++;
    if (nw !== 2) begin n_fail++; $display("FAIL store_write_count got=%0d want=2", nw); end
    gold[32'h200] = 8'hDD; gold[32'h201] = 8'hCC;
    run_xfer(1'b0, 1'b0, 2'b10, 32'h1FF, '0, rel, d, t0);
    n_tests++;
    if (d !== gold_word(32'h1FF, 4)) begin
      n_fail++; $display("FAIL store_readback got=%h want=%h", d, gold_word(32'h1FF, 4));
    end
  endtask

  task automatic test_arbitration();
    int t0, mrel, irel; logic [31:0] md, id; logic [32:0] ta;
    preload(32'h300, 8'h80);
    tq.delete();
    @(negedge clk);
    t0 = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_len = 2'b00; bus.mem_addr = 32'h300;
    mrel = -1; irel = -1; md = 'x; id = 'x;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.mem_ack && mrel < 0) begin mrel = cyc - t0; md = bus.mem_rdata; bus.mem_req = 1'b0; end
      if (bus.if_ack) begin irel = cyc - t0; id = bus.if_data; break; end
    end
    bus.if_req = 1'b0; bus.mem_req = 1'b0;
    n_tests++;
    if (mrel !== 3) begin n_fail++; $display("FAIL arb_mem_ack_cycle got=%0d want=3", mrel); end
    n_tests++;
    if (md !== 32'h00000080) begin n_fail++; $display("FAIL arb_mem_rdata got=%h want=00000080", md); end
    ta = trace_at(t0 + 4);
    n_tests++;
    if (ta !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL arb_if_grant got a=%h want=00000100", ta[31:0]); end
    n_tests++;
    if (irel !== 9 || id !== gold_word(32'h100, 4)) begin
      n_fail++; $display("FAIL arb_if_ack got cyc=%0d d=%h want cyc=9 d=%h", irel, id, gold_word(32'h100, 4));
    end
  endtask

  task automatic test_flush();
    int t0, rel, seen; logic [31:0] d;
    // Flush mid-fetch, then a fresh fetch at 0x40.
    @(negedge clk);
    t0 = cyc; seen = 0;
    bus.if_req = 1'b1; bus.if_addr = 32'h500;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.if_ack) seen++;
      if (k == 3) begin bus.flush = 1'b1; bus.if_req = 1'b0; end
      if (k == 4) begin
        n_tests++;
        if (bus.ram_a !== 32'h0 || bus.ram_wr !== 1'b0) begin
          n_fail++; $display("FAIL flush_idle got a=%h wr=%b want a=0 wr=0", bus.ram_a, bus.ram_wr);
        end
        bus.flush = 1'b0;
      end
    end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("FAIL flush_no_ack got=%0d acks want=0", seen); end
    run_xfer(1'b1, 1'b0, 2'b10, 32'h40, '0, rel, d, t0);
    n_tests++;
    if (rel !== 6 || d !== gold_word(32'h40, 4)) begin
      n_fail++; $display("FAIL flush_refetch got cyc=%0d d=%h want cyc=6 d=%h", rel, d, gold_word(32'h40, 4));
    end
    // Flush on the completing edge.
    @(negedge clk);
    t0 = cyc; seen = 0;
    bus.if_req = 1'b1; bus.if_addr = 32'h600;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.if_ack) seen++;
      if (k == 5) begin bus.flush = 1'b1; bus.if_req = 1'b0; end
      if (k == 6) bus.flush = 1'b0;
    end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("FAIL flush_last_edge got=%0d acks want=0", seen); end
    // Flush in IDLE delays the grant by one cycle.
    @(negedge clk);
    t0 = cyc; rel = -1;
    bus.if_req = 1'b1; bus.if_addr = 32'h104; bus.flush = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) bus.flush = 1'b0;
      if (bus.if_ack) begin rel = cyc - t0; break; end
    end
    bus.if_req = 1'b0;
    n_tests++;
    if (rel !== 7) begin n_fail++; $display("FAIL flush_idle_block got cyc=%0d want=7", rel); end
    // Flush has no effect on a load.
    @(negedge clk);
    t0 = cyc; rel = -1; d = 'x;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_len = 2'b11; bus.mem_addr = 32'h100;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      bus.flush = (k == 2);
      if (bus.mem_ack) begin rel = cyc - t0; d = bus.mem_rdata; break; end
    end
    bus.mem_req = 1'b0; bus.flush = 1'b0;
    n_tests++;
    if (rel !== 6 || d !== gold_word(32'h100, 4)) begin
      n_fail++; $display("FAIL flush_mem_immune got cyc=%0d d=%h want cyc=6 d=%h", rel, d, gold_word(32'h100, 4));
    end
  endtask

  task automatic test_wrap();
    int rel, t0; logic [31:0] d; logic [32:0] ta; logic [31:0] base;
    base = 32'hFFFFFFFE;
    tq.delete();
    run_xfer(1'b0, 1'b0, 2'b10, base, '0, rel, d, t0);
    for (int i = 0; i < 4; i++) begin
      ta = trace_at(t0 + 1 + i);
      n_tests++;
      if (ta !== {1'b1, base + 32'(i)}) begin
        n_fail++; $display("FAIL wrap_addr_%0d got=%h want=%h", i, ta[31:0], base + 32'(i));
      end
    end
    n_tests++;
    if (rel !== 6 || d !== gold_word(base, 4)) begin
      n_fail++; $display("FAIL wrap_data got cyc=%0d d=%h want cyc=6 d=%h", rel, d, gold_word(base, 4));
    end
  endtask

  task automatic test_reset_mid_store();
    int t0, seen, nw, rel; logic [31:0] d;
    tq.delete();
    @(negedge clk);
    t0 = cyc;
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'b10;
    bus.mem_addr = 32'h700; bus.mem_wdata = 32'h44332211;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.ram_wr !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wr got=%b want=0", bus.ram_wr); end
    bus.mem_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.mem_ack) seen++;
    end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_no_ack got=%0d acks want=0", seen); end
    nw = 0;
    foreach (tq[j]) if (tq[j].wr) nw++;
    n_tests++;
    if (nw !== 1) begin n_fail++; $display("FAIL rst_mid_writes got=%0d want=1", nw); end
    gold[32'h700] = 8'h11;
    run_xfer(1'b0, 1'b0, 2'b10, 32'h700, '0, rel, d, t0);
    n_tests++;
    if (d !== gold_word(32'h700, 4)) begin
      n_fail++; $display("FAIL rst_mid_readback got=%h want=%h", d, gold_word(32'h700, 4));
    end
  endtask

  task automatic test_random();
    int rel, t0, n, kind, nw, exp_rel; logic [31:0] d, addr, wdata, exp_a; logic [1:0] len; logic [7:0] exp_d;
    for (int it = 0; it < 40; it++) begin
      kind  = $urandom_range(0, 2);
      len   = 2'($urandom_range(0, 3));
      addr  = ($urandom_range(0, 7) == 0) ? $urandom : 32'h1000 + 32'($urandom_range(0, 31));
      wdata = $urandom;
      n     = (kind == 0) ? 4 : nbytes(len);
      tq.delete();
      run_xfer(kind == 0, kind == 2, len, addr, wdata, rel, d, t0);
      exp_rel = (kind == 2) ? n + 1 : n + 2;
      n_tests++;
      if (rel !== exp_rel) begin
        n_fail++; $display("FAIL rnd%0d_ack_cycle kind=%0d got=%0d want=%0d", it, kind, rel, exp_rel);
      end
      if (kind != 2) begin
        n_tests++;
        if (d !== gold_word(addr, n)) begin
          n_fail++; $display("FAIL rnd%0d_rdata a=%h got=%h want=%h", it, addr, d, gold_word(addr, n));
        end
      end
      nw = 0;
      foreach (tq[j]) begin
        if (tq[j].wr) begin
          exp_a = addr + 32'(nw);
          exp_d = 8'(wdata >> (8 * nw));
          n_tests++;
          if (tq[j].c - t0 !== nw + 1 || tq[j].a !== exp_a || tq[j].d !== exp_d) begin
            n_fail++;
            $display("FAIL rnd%0d_write%0d got cyc=%0d a=%h d=%h want cyc=%0d a=%h d=%h", it, nw,
                     tq[j].c - t0, tq[j].a, tq[j].d, nw + 1, exp_a, exp_d);
          end
          nw++;
        end
      end
      n_tests++;
      if (nw !== ((kind == 2) ? n : 0)) begin
        n_fail++; $display("FAIL rnd%0d_write_count got=%0d want=%0d", it, nw, (kind == 2) ? n : 0);
      end
      if (kind == 2) for (int i = 0; i < n; i++) gold[addr + 32'(i)] = 8'(wdata >> (8 * i));
    end
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0; bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    bus.mem_len = '0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.flush = 1'b0;
    test_reset();
    test_if_fetch();
    test_store_half();
    test_arbitration();
    test_flush();
    test_wrap();
    test_reset_mid_store();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog tests_run=%0d expired before completion", n_tests);
    $fatal(1);
  end

endmodule
